// File: rtl/i2s_rx_front.sv
// I2S receiver front end: oversamples bclk/lrclk/sdata in the clk domain and
// deserialises one channel into a parallel word with a one-cycle strobe.
module i2s_rx_front #(
    parameter int DATA_SIZE = 24,
    parameter int CHANNEL   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i2s_bclk,
    input  logic                 i2s_lrclk,
    input  logic                 i2s_sdata,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 sample_trig,
    output logic                 frame_err
);

    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam logic SEL = (CHANNEL != 0);
    localparam logic [CW-1:0] FULL = CW'(DATA_SIZE);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        SHIFT,
        HOLD
    } state_t;

    logic bclk_s1, bclk_s2, bclk_d;
    logic lr_s1, lr_s2;
    logic sd_s1, sd_s2;

    state_t               state, state_n;
    logic                 lr_prev, lr_prev_n;
    logic                 chan, chan_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [DATA_SIZE-1:0] shreg, shreg_n;
    logic [DATA_SIZE-1:0] word_q, word_n;
    logic                 dlv_q, dlv_n;
    logic                 err_q, err_n;

    logic                 bclk_rise;
    logic                 trans;
    logic                 done;
    logic [CW-1:0]        cnt_inc;
    logic [DATA_SIZE-1:0] shifted;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_s1     <= 1'b0;
            bclk_s2     <= 1'b0;
            bclk_d      <= 1'b0;
            lr_s1       <= 1'b0;
            lr_s2       <= 1'b0;
            sd_s1       <= 1'b0;
            sd_s2       <= 1'b0;
            state       <= WAIT_FRAME;
            lr_prev     <= 1'b0;
            chan        <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
            word_q      <= '0;
            dlv_q       <= 1'b0;
            err_q       <= 1'b0;
            data_out    <= '0;
            sample_trig <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            bclk_s1     <= i2s_bclk;
            bclk_s2     <= bclk_s1;
            bclk_d      <= bclk_s2;
            lr_s1       <= i2s_lrclk;
            lr_s2       <= lr_s1;
            sd_s1       <= i2s_sdata;
            sd_s2       <= sd_s1;
            state       <= state_n;
            lr_prev     <= lr_prev_n;
            chan        <= chan_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            word_q      <= word_n;
            dlv_q       <= dlv_n;
            err_q       <= err_n;
            sample_trig <= dlv_q;
            frame_err   <= err_q;
            if (dlv_q) begin
                data_out <= word_q;
            end
        end
    end

    always_comb begin
        bclk_rise = bclk_s2 & ~bclk_d;
        trans     = lr_s2 != lr_prev;
        shifted   = {shreg[DATA_SIZE-2:0], sd_s2};
        cnt_inc   = cnt + 1'b1;
        done      = (cnt_inc == FULL);

        state_n   = state;
        lr_prev_n = lr_prev;
        chan_n    = chan;
        cnt_n     = cnt;
        shreg_n   = shreg;
        word_n    = word_q;
        dlv_n     = 1'b0;
        err_n     = 1'b0;

        if (bclk_rise) begin
            lr_prev_n = lr_s2;
            unique case (state)
                WAIT_FRAME: begin
                    if (trans) begin
                        chan_n  = lr_s2;
                        cnt_n   = '0;
                        shreg_n = '0;
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    // The transition edge still carries the old slot's LSB.
                    shreg_n = shifted;
                    cnt_n   = cnt_inc;
                    if (done) begin
                        state_n = HOLD;
                        if (chan == SEL) begin
                            dlv_n  = 1'b1;
                            word_n = shifted;
                        end
                    end
                    if (trans) begin
                        err_n   = ~done;
                        chan_n  = lr_s2;
                        cnt_n   = '0;
                        shreg_n = '0;
                        state_n = SHIFT;
                    end
                end
                HOLD: begin
                    if (trans) begin
                        chan_n  = lr_s2;
                        cnt_n   = '0;
                        shreg_n = '0;
                        state_n = SHIFT;
                    end
                end
                default: begin
                    state_n = WAIT_FRAME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx_front.sv
// Directed bench for i2s_rx_front: one left-channel and one right-channel
// instance fed by the same I2S stream.
module tb_i2s_rx_front;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic [23:0] data0, data1;
    logic        trig0, trig1;
    logic        err0, err1;

    int passed = 0;
    int total = 0;

    int trig0_n = 0, trig1_n = 0, err0_n = 0, err1_n = 0;
    int wide_n = 0;
    logic [23:0] last0 = '0, last1 = '0;
    logic p_trig0 = 0, p_trig1 = 0, p_err0 = 0, p_err1 = 0;
    logic carry = 1'b0;

    always #5 clk = ~clk;

    i2s_rx_front #(.DATA_SIZE(24), .CHANNEL(0)) dut0 (
        .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .data_out(data0), .sample_trig(trig0), .frame_err(err0)
    );

    i2s_rx_front #(.DATA_SIZE(24), .CHANNEL(1)) dut1 (
        .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .data_out(data1), .sample_trig(trig1), .frame_err(err1)
    );

    // Pulse counting and width tracking, sampled away from the active edge.
    always @(negedge clk) begin
        if (trig0) begin
            trig0_n++;
            last0 = data0;
            if (p_trig0) wide_n++;
        end
        if (trig1) begin
            trig1_n++;
            last1 = data1;
            if (p_trig1) wide_n++;
        end
        if (err0) begin
            err0_n++;
            if (p_err0) wide_n++;
        end
        if (err1) begin
            err1_n++;
            if (p_err1) wide_n++;
        end
        p_trig0 = trig0;
        p_trig1 = trig1;
        p_err0  = err0;
        p_err1  = err1;
    end

    // Slot periods j in [first,stop); period 0 carries the previous slot's LSB.
    task automatic send_part(input logic lr, input logic [23:0] w,
                             input int len, input int first, input int stop);
        for (int j = first; j < stop; j++) begin
            i2s_bclk  = 1'b0;
            i2s_lrclk = lr;
            if (j == 0) i2s_sdata = carry;
            else if (j <= 24) i2s_sdata = w[24-j];
            else i2s_sdata = 1'b0;
            #40;
            i2s_bclk = 1'b1;
            #40;
        end
        if (stop == len) begin
            if (len - 1 < 24) carry = w[24-len];
            else carry = 1'b0;
        end
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] w, input int len);
        send_part(lr, w, len, 0, len);
    endtask

    task automatic settle();
        i2s_bclk = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            i2s_bclk = ~i2s_bclk;
            @(negedge clk);
            total++;
            if (data0 !== 24'h0 || trig0 !== 1'b0 || err0 !== 1'b0) begin
                $display("FAIL reset_outputs cycle %0d: data=%h trig=%b err=%b, need 0/0/0",
                         i, data0, trig0, err0);
                bad++;
            end else passed++;
        end
        i2s_bclk = 1'b0;
        carry = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int t0 = trig0_n;
        int e0 = err0_n;
        int w0 = wide_n;
        send_slot(1'b1, 24'h123456, 32);
        for (int f = 0; f < 3; f++) begin
            send_slot(1'b0, 24'hABCDEF, 32);
            send_slot(1'b1, 24'h123456, 32);
        end
        settle();
        total++;
        if (trig0_n - t0 !== 3) begin
            $display("FAIL nominal_trig_count: got %0d, need 3", trig0_n - t0);
        end else passed++;
        total++;
        if (last0 !== 24'hABCDEF) begin
            $display("FAIL nominal_data: got %h, need abcdef", last0);
        end else passed++;
        total++;
        if (err0_n - e0 !== 0) begin
            $display("FAIL nominal_frame_err: got %0d, need 0", err0_n - e0);
        end else passed++;
        total++;
        if (wide_n - w0 !== 0) begin
            $display("FAIL nominal_pulse_width: %0d wide pulses, need 0", wide_n - w0);
        end else passed++;
    endtask

    task automatic test_mid_start();
        int t0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        carry = 1'b0;
        t0 = trig0_n;
        send_part(1'b0, 24'hFFFFFF, 32, 20, 32);
        send_slot(1'b1, 24'h654321, 32);
        total++;
        if (trig0_n - t0 !== 0) begin
            $display("FAIL mid_start_early_trig: got %0d, need 0", trig0_n - t0);
        end else passed++;
        send_slot(1'b0, 24'h5A5A5A, 32);
        send_slot(1'b1, 24'h654321, 32);
        settle();
        total++;
        if (trig0_n - t0 !== 1) begin
            $display("FAIL mid_start_trig_count: got %0d, need 1", trig0_n - t0);
        end else passed++;
        total++;
        if (last0 !== 24'h5A5A5A) begin
            $display("FAIL mid_start_data: got %h, need 5a5a5a", last0);
        end else passed++;
    endtask

    task automatic test_short_slot();
        int t0 = trig0_n;
        int e0 = err0_n;
        send_slot(1'b0, 24'h111111, 16);
        send_slot(1'b1, 24'h222222, 32);
        settle();
        total++;
        if (err0_n - e0 !== 1) begin
            $display("FAIL short_frame_err: got %0d, need 1", err0_n - e0);
        end else passed++;
        total++;
        if (trig0_n - t0 !== 0) begin
            $display("FAIL short_trig: got %0d, need 0", trig0_n - t0);
        end else passed++;
        total++;
        if (data0 !== 24'h5A5A5A) begin
            $display("FAIL short_data_held: got %h, need 5a5a5a", data0);
        end else passed++;
        send_slot(1'b0, 24'h0F0F0F, 32);
        send_slot(1'b1, 24'h222222, 32);
        settle();
        total++;
        if (trig0_n - t0 !== 1 || last0 !== 24'h0F0F0F) begin
            $display("FAIL short_recover: count %0d data %h, need 1 0f0f0f",
                     trig0_n - t0, last0);
        end else passed++;
        total++;
        if (err0_n - e0 !== 1) begin
            $display("FAIL short_recover_err: got %0d, need 1", err0_n - e0);
        end else passed++;
    endtask

    task automatic test_exact_slot();
        int t0 = trig0_n;
        int t1 = trig1_n;
        int e0 = err0_n;
        int e1 = err1_n;
        for (int f = 0; f < 2; f++) begin
            send_slot(1'b0, 24'h800000, 24);
            send_slot(1'b1, 24'h7FFFFF, 24);
        end
        send_slot(1'b0, 24'h000000, 2);
        settle();
        total++;
        if (trig0_n - t0 !== 2 || last0 !== 24'h800000) begin
            $display("FAIL exact_left: count %0d data %h, need 2 800000",
                     trig0_n - t0, last0);
        end else passed++;
        total++;
        if (err0_n - e0 !== 0) begin
            $display("FAIL exact_left_err: got %0d, need 0", err0_n - e0);
        end else passed++;
        total++;
        if (trig1_n - t1 !== 2 || last1 !== 24'h7FFFFF) begin
            $display("FAIL exact_right: count %0d data %h, need 2 7fffff",
                     trig1_n - t1, last1);
        end else passed++;
        total++;
        if (err1_n - e1 !== 0) begin
            $display("FAIL exact_right_err: got %0d, need 0", err1_n - e1);
        end else passed++;
    endtask

    task automatic test_reset_mid_word();
        int t0;
        send_slot(1'b1, 24'h333333, 32);
        send_part(1'b0, 24'hC3C3C3, 32, 0, 10);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (data0 !== 24'h0 || trig0 !== 1'b0 || err0 !== 1'b0) begin
            $display("FAIL reset_mid_outputs: data=%h trig=%b err=%b, need 0/0/0",
                     data0, trig0, err0);
        end else passed++;
        reset = 1'b1;
        carry = 1'b0;
        t0 = trig0_n;
        send_part(1'b0, 24'hC3C3C3, 32, 10, 32);
        settle();
        total++;
        if (trig0_n - t0 !== 0) begin
            $display("FAIL reset_mid_partial: got %0d trig, need 0", trig0_n - t0);
        end else passed++;
        send_slot(1'b1, 24'h333333, 32);
        send_slot(1'b0, 24'h3C3C3C, 32);
        send_slot(1'b1, 24'h333333, 32);
        settle();
        total++;
        if (trig0_n - t0 !== 1 || last0 !== 24'h3C3C3C) begin
            $display("FAIL reset_mid_next: count %0d data %h, need 1 3c3c3c",
                     trig0_n - t0, last0);
        end else passed++;
        total++;
        if (wide_n !== 0) begin
            $display("FAIL pulse_width_overall: %0d wide pulses, need 0", wide_n);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mid_start();
        test_short_slot();
        test_exact_slot();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
